// File: rtl/mmu_feed_sched.sv
// Skewed FIFO read-enable scheduler that streams one tile into the systolic MMU.
// Optional macro MMU_FEED_PERF_CNT_EN adds a saturating stall_cycles counter port.
module mmu_feed_sched #(
  parameter int ARRAY_WIDTH = 4,
  parameter int LEN_W       = 8,
  localparam int STEP_W     = LEN_W + $clog2(ARRAY_WIDTH) + 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [LEN_W-1:0]       len,
  input  logic                   stall,
  input  logic                   abort,
  output logic [ARRAY_WIDTH-1:0] fifo_en,
  output logic                   busy,
  output logic                   done,
`ifdef MMU_FEED_PERF_CNT_EN
  output logic [15:0]            stall_cycles,
`endif
  output logic [STEP_W-1:0]      step
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [STEP_W-1:0]  k_q, k_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [STEP_W-1:0]  len_ext_s;
  logic [STEP_W-1:0]  last_k_s;

  assign len_ext_s = STEP_W'(len_q);
  assign last_k_s  = len_ext_s + STEP_W'(ARRAY_WIDTH - 2);
  assign step      = k_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      len_q   <= len_d;
    end
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    len_d   = len_q;
    fifo_en = '0;
    busy    = (state_q != S_IDLE);
    done    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          len_d   = len;
          k_d     = '0;
          state_d = (len == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        // abort outranks both stall and the end-of-tile exit
        if (abort) begin
          state_d = S_IDLE;
        end else if (!stall) begin
          for (int i = 0; i < ARRAY_WIDTH; i++) begin
            fifo_en[i] = (k_q >= STEP_W'(i)) && (k_q < (STEP_W'(i) + len_ext_s));
          end
          k_d = k_q + STEP_W'(1);
          if (k_q == last_k_s) begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        done    = !abort;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

`ifdef MMU_FEED_PERF_CNT_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  assign stall_cycles = stall_cnt_q;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (state_q == S_IDLE && start) begin
      stall_cnt_d = '0;
    end else if (state_q == S_RUN && stall && stall_cnt_q != 16'hFFFF) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end
`endif

endmodule
